// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM states, slice
// width and the index-width helper.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble index still needs one bit to exist as a register.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand request and result channels of the nibble-serial adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  // Both channels: a transfer happens on a rising edge where valid and ready
  // are both high; the producer holds its payload stable until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_carryskip.sv
// 4-bit carry-skip adder slice: ripple carry with a bypass when every bit
// propagates.
module Carryskip_Adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum_o  = p ^ c[3:0];
    cout_o = (&p) ? cin_i : c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams operands through one 4-bit
// carry-skip slice, LSB nibble first, with the carry registered in between.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus,
  output state_t                dbg_state_o
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   slice_a;
  logic [NIB_W-1:0]   slice_b;
  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[NIB_W*idx_q +: NIB_W];
  assign slice_b = b_q[NIB_W*idx_q +: NIB_W];

  Carryskip_Adder u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[NIB_W*idx_q +: NIB_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          // Slice sum bit 3 is the final sum MSB on the last nibble.
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_sum[NIB_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state_o   = state_q;

endmodule
